// File: rtl/async_transmitter.sv
// UART transmit engine: small circular FIFO feeding a start/8-data/[parity]/stop serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit.
module async_transmitter #(
  parameter int FifoDepthLog2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BitTick,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       TxD_full,
  output logic       TxD_overflow
);

  localparam int Depth = 1 << FifoDepthLog2;

  typedef enum logic [3:0] {
    IDLE,
    START,
    D0, D1, D2, D3, D4, D5, D6, D7,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } txState_t;

  txState_t state;

  logic [7:0]             fifoMem [Depth];
  logic [FifoDepthLog2:0] wrPtr;
  logic [FifoDepthLog2:0] rdPtr;
  logic [FifoDepthLog2:0] wrPtrNext;
  logic [FifoDepthLog2:0] rdPtrNext;
  logic [7:0]             fifoHead;
  logic [7:0]             shiftReg;
  logic                   fifoEmpty;
  logic                   push;
  logic                   pop;
`ifdef UART_TX_PARITY_EN
  logic                   parityBit;
`endif

  // Full is taken from the registered flag, so a push alongside a pop on a full FIFO is still dropped.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign push      = TxD_start && !TxD_full;
  assign pop       = BitTick && !fifoEmpty && ((state == IDLE) || (state == STOP));
  assign wrPtrNext = push ? wrPtr + 1'b1 : wrPtr;
  assign rdPtrNext = pop ? rdPtr + 1'b1 : rdPtr;
  assign fifoHead  = fifoMem[rdPtr[FifoDepthLog2-1:0]];

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifoMem[wrPtr[FifoDepthLog2-1:0]] <= TxD_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      TxD_full     <= 1'b0;
      TxD_overflow <= 1'b0;
    end else begin
      wrPtr        <= wrPtrNext;
      rdPtr        <= rdPtrNext;
      TxD_full     <= (wrPtrNext[FifoDepthLog2-1:0] == rdPtrNext[FifoDepthLog2-1:0]) &&
                      (wrPtrNext[FifoDepthLog2] != rdPtrNext[FifoDepthLog2]);
      TxD_overflow <= TxD_start && TxD_full;
    end
  end

  // Line FSM; the enum is ordered so START..D6 simply step to the next encoding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      TxD       <= 1'b1;
      TxD_busy  <= 1'b0;
      shiftReg  <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      TxD_busy <= (state != IDLE) || !fifoEmpty;
      if (BitTick) begin
        case (state)
          IDLE, STOP: begin
            if (pop) begin
              shiftReg  <= fifoHead;
`ifdef UART_TX_PARITY_EN
              parityBit <= ^fifoHead;
`endif
              TxD       <= 1'b0;
              state     <= START;
            end else begin
              TxD   <= 1'b1;
              state <= IDLE;
            end
          end
          D7: begin
`ifdef UART_TX_PARITY_EN
            TxD   <= parityBit;
            state <= PARITY;
`else
            TxD   <= 1'b1;
            state <= STOP;
`endif
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            TxD   <= 1'b1;
            state <= STOP;
          end
`endif
          default: begin
            TxD      <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
            state    <= txState_t'(state + 4'd1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_async_transmitter.sv
// Directed bench for async_transmitter: frame table plus back-to-back, overflow, reset and same-cycle cases.
module tb_async_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FrameLen = 11;
`else
  localparam int FrameLen = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       BitTick;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD;
  logic       TxD_busy;
  logic       TxD_full;
  logic       TxD_overflow;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs [6];

  async_transmitter #(.FifoDepthLog2(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .BitTick     (BitTick),
    .TxD_start   (TxD_start),
    .TxD_data    (TxD_data),
    .TxD         (TxD),
    .TxD_busy    (TxD_busy),
    .TxD_full    (TxD_full),
    .TxD_overflow(TxD_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic tick, input logic start, input logic [7:0] data);
    BitTick   = tick;
    TxD_start = start;
    TxD_data  = data;
    @(posedge clk);
    #1;
    BitTick   = 1'b0;
    TxD_start = 1'b0;
  endtask

  task automatic sendTick();
    repeat (15) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Line level of bit k of a frame, in transmission order; anything past the stop bit is idle.
  function automatic logic lineBit(input logic [7:0] d, input int k);
    logic [7:0] s;
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      s = d >> (k - 1);
      return s[0];
    end
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic checkFrameFrom(input string name, input logic [7:0] d, input int first);
    for (int k = first; k < FrameLen; k++) begin
      sendTick();
      checkOutput($sformatf("%s_bit%0d", name, k), TxD, lineBit(d, k));
    end
  endtask

  initial begin
    logic [21:0] pairSeq;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    BitTick   = 1'b0;
    TxD_start = 1'b0;
    TxD_data  = 8'h00;

    // Time-ordered line bits (MSB first): start, D0..D7, [parity], stop, idle.
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 12'b0_10101010_0_1_1};
    vecs[1] = '{8'hA3, 12'b0_11000101_0_1_1};
    vecs[2] = '{8'h0F, 12'b0_11110000_0_1_1};
    vecs[3] = '{8'h07, 12'b0_11100000_1_1_1};
    vecs[4] = '{8'h03, 12'b0_11000000_0_1_1};
    vecs[5] = '{8'h80, 12'b0_00000001_1_1_1};
    pairSeq = 22'b0_11000101_0_1_0_11110000_0_1;
`else
    vecs[0] = '{8'h55, {10'b0_10101010_1, 2'b11}};
    vecs[1] = '{8'hA3, {10'b0_11000101_1, 2'b11}};
    vecs[2] = '{8'h0F, {10'b0_11110000_1, 2'b11}};
    vecs[3] = '{8'h07, {10'b0_11100000_1, 2'b11}};
    vecs[4] = '{8'h03, {10'b0_11000000_1, 2'b11}};
    vecs[5] = '{8'h80, {10'b0_00000001_1, 2'b11}};
    pairSeq = {20'b0_11000101_1_0_11110000_1, 2'b11};
`endif

    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("resetTxD", TxD, 1'b1);
    checkOutput("resetBusy", TxD_busy, 1'b0);
    checkOutput("resetFull", TxD_full, 1'b0);
    checkOutput("resetOverflow", TxD_overflow, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].data);
      checkOutput($sformatf("vec%0d_preTick", i), TxD, 1'b1);
      for (int k = 0; k <= FrameLen; k++) begin
        sendTick();
        checkOutput($sformatf("vec%0d_bit%0d", i, k), TxD, vecs[i].frame[11-k]);
      end
      checkOutput($sformatf("vec%0d_busyStillHigh", i), TxD_busy, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("vec%0d_busyFall", i), TxD_busy, 1'b0);
    end

    // Back-to-back frames with no idle bit between them.
    applyStimulus(1'b0, 1'b1, 8'hA3);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h0F);
    for (int k = 0; k < 2 * FrameLen; k++) begin
      sendTick();
      checkOutput($sformatf("pair_bit%0d", k), TxD, pairSeq[21-k]);
    end
    sendTick();
    checkOutput("pair_idle", TxD, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pair_busyFall", TxD_busy, 1'b0);

    // Fill the FIFO with ticks held low, then overflow it once.
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b1, 8'h33);
    checkOutput("ovf_fullAfter3", TxD_full, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h44);
    checkOutput("ovf_fullAfter4", TxD_full, 1'b1);
    checkOutput("ovf_noPulseAfter4", TxD_overflow, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("ovf_pulse", TxD_overflow, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("ovf_pulseEnds", TxD_overflow, 1'b0);
    checkOutput("ovf_stillFull", TxD_full, 1'b1);
    sendTick();
    checkOutput("ovf_f0_bit0", TxD, 1'b0);
    checkOutput("ovf_fullClears", TxD_full, 1'b0);
    checkFrameFrom("ovf_f0", 8'h11, 1);
    checkFrameFrom("ovf_f1", 8'h22, 0);
    checkFrameFrom("ovf_f2", 8'h33, 0);
    checkFrameFrom("ovf_f3", 8'h44, 0);
    for (int k = 0; k < 3; k++) begin
      sendTick();
      checkOutput($sformatf("ovf_noFifth%0d", k), TxD, 1'b1);
    end
    checkOutput("ovf_busyDone", TxD_busy, 1'b0);

    // Reset in D3 with two bytes still queued; a push during reset is ignored.
    applyStimulus(1'b0, 1'b1, 8'hF0);
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    repeat (5) sendTick();
    checkOutput("rst_inD3", TxD, 1'b0);
    checkOutput("rst_busyBefore", TxD_busy, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    rst_n = 1'b1;
    checkOutput("rst_TxD", TxD, 1'b1);
    checkOutput("rst_busy", TxD_busy, 1'b0);
    checkOutput("rst_full", TxD_full, 1'b0);
    for (int k = 0; k < 12; k++) begin
      sendTick();
      checkOutput($sformatf("rst_quiet%0d", k), TxD, 1'b1);
    end
    checkOutput("rst_busyAfter", TxD_busy, 1'b0);

    // Push coinciding with a tick on an empty FIFO defers the start bit by one tick.
    applyStimulus(1'b1, 1'b1, 8'h3C);
    checkOutput("same_holdHigh", TxD, 1'b1);
    sendTick();
    checkOutput("same_start", TxD, 1'b0);
    checkFrameFrom("same", 8'h3C, 1);
    sendTick();
    checkOutput("same_idle", TxD, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_transmitter.md
# async_transmitter

UART transmit engine with a small input FIFO: accepts bytes over a valid/full handshake and serializes each as start bit, 8 data bits LSB first, optional even parity, and one stop bit on `TxD`. Bit timing comes from an external one-cycle `BitTick` pulse (one per bit period) generated by the shared baud tick generator. It is the transmit-side counterpart of the UART receiver in the same link and uses the same 8N1 frame format.

## Interface
- `FifoDepthLog2`, default 2: FIFO depth = 2^FifoDepthLog2 entries (legal range 1..4).
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: synchronous reset, active-low, sampled on the rising edge of `clk`.
- `BitTick` input 1: one-`clk` pulse per bit period, free-running.
- `TxD_start` input 1: push request; the byte on `TxD_data` is written this cycle if `TxD_full`=0.
- `TxD_data` input 8: byte to enqueue.
- `TxD` output 1: serial line, registered, idle high.
- `TxD_busy` output 1: high while a frame is on the line or the FIFO is non-empty.
- `TxD_full` output 1: FIFO full, registered.
- `TxD_overflow` output 1: one-cycle pulse when a push is dropped because the FIFO is full.

## Operation
- FIFO: circular buffer, read/write pointers FifoDepthLog2+1 bits wide (extra wrap bit). Full when the low bits are equal and the MSBs differ; empty when all bits are equal.
- Push: `TxD_start && !TxD_full` writes the byte and increments the write pointer.
- Push while full: the byte is discarded, pointers are unchanged, and `TxD_overflow`=1 on the next cycle.
- Pop: performed only by the FSM on the start-bit transition (see below).
- Simultaneous push and pop when full: the push is still rejected, because `TxD_full` is evaluated before the pop. There is no bypass.
- FSM states: IDLE, START, D0..D7, PARITY (only when the parity macro is compiled in), STOP.
- All state transitions occur only on cycles with `BitTick`=1. The exception is reset.
- IDLE: `TxD`=1. On `BitTick`, if the FIFO is non-empty: pop into the shift register, `TxD`<=0, go to START.
- START → D0 … D7: on each `BitTick`, `TxD`<=shift[0], shift right by one, advance one state.
- D7 → PARITY or STOP. PARITY drives the XOR of the 8 data bits, which gives even parity.
- STOP: `TxD`<=1 for one bit period.
- On the `BitTick` that leaves STOP:
  - FIFO non-empty: pop and go directly to START with `TxD`<=0. Frames go back-to-back with no idle bit.
  - FIFO empty: go to IDLE.
- `TxD_busy` = (state != IDLE) || FIFO non-empty, registered.
- Reset (`rst_n`=0 at a clock edge), including mid-frame:
  - state=IDLE, `TxD`=1, pointers=0, `TxD_busy`=0, `TxD_full`=0, `TxD_overflow`=0.
  - The partial frame is truncated and FIFO contents are lost.
- A push in the same cycle as reset is ignored.

## Timing
- All outputs are registered. `TxD` changes on the clock edge at which `BitTick` is sampled high.
- Each line bit lasts exactly one `BitTick` interval.
- Frame length is 10 `BitTick` intervals (11 with parity).
- Enqueue latency: the byte is visible to the FSM on the cycle after the push. The start bit begins at the first `BitTick` sampled at least one cycle after the push.
- A push and a `BitTick` in the same cycle into an empty FIFO: the start bit is deferred to the next `BitTick`.
- `TxD_full` asserts the cycle after the push that fills the FIFO. It deasserts the cycle after the pop.
- `TxD_busy` deasserts one cycle after the FSM enters IDLE with the FIFO empty.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state present.
  - Frame = start, D0..D7, even parity bit, stop (11 bit periods).
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Frame = 8N1 (10 bit periods).

## Test plan
- Reset, then one push of 0x55 with `BitTick` every 16 clks → `TxD` per tick: 0,1,0,1,0,1,0,1,0,1, then idle high. `TxD_busy` falls one clk after the stop period ends.
- Push 0xA3 then 0x0F back-to-back, 2 clks apart → two frames with no idle gap. `TxD`: 0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1.
- `FifoDepthLog2`=2, hold `BitTick` low, push 5 bytes on consecutive clks:
  - `TxD_full`=1 after the 4th push.
  - 5th push → `TxD_overflow` pulse of 1 clk.
  - Release ticks → exactly 4 frames, in order.
- Assert `rst_n`=0 during D3 of a frame with 2 bytes queued → next cycle `TxD`=1, `TxD_busy`=0, `TxD_full`=0. No further frames after release.
- With `UART_TX_PARITY_EN`: push 0x07 → parity bit 1, frame spans 11 ticks. Push 0x03 → parity bit 0.
- Push and `BitTick` in the same clk with the FIFO empty and IDLE → `TxD` stays 1 at that tick and goes low at the following tick.
